// File: rtl/string_move_collector.sv
// Move-request initiator for the search engine: fetches moves one handshake at a time
// and buffers them in a first-word-fall-through FIFO for a downstream valid/ready consumer.
module string_move_collector #(
  parameter int PIN_W = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] move_limit,
  output logic             search_req_val,
  input  logic             search_resp_val,
  output logic             search_resp_rdy,
  input  logic [PIN_W-1:0] search_pin_1,
  input  logic [PIN_W-1:0] search_pin_2,
  input  logic             search_add_or_remove,
  input  logic             search_done,
  output logic             move_val,
  input  logic             move_rdy,
  output logic [PIN_W-1:0] move_pin_1,
  output logic [PIN_W-1:0] move_pin_2,
  output logic             move_add,
  output logic [CNT_W-1:0] move_count,
  output logic             busy,
  output logic             finished
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * PIN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_GAP   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic           req_val_q, req_val_d;
  logic           busy_q, busy_d;
  logic           finished_q, finished_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]  mem_q [DEPTH];

  logic          empty_s, full_s, push_s, pop_s, limit_hit_s;
  logic [EW-1:0] head_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_s     = (wr_ptr_q == rd_ptr_q);
  assign full_s      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign search_resp_rdy = (state_q == S_RESP) && !full_s;
  assign push_s      = search_resp_rdy && search_resp_val;
  assign pop_s       = !empty_s && move_rdy;
  assign limit_hit_s = (limit_q != {CNT_W{1'b0}}) && (count_q == limit_q);
  assign head_s      = mem_q[rd_ptr_q[AW-1:0]];

  assign search_req_val = req_val_q;
  assign busy           = busy_q;
  assign finished       = finished_q;
  assign move_count     = count_q;
  assign move_val       = !empty_s;
  assign move_add       = move_val ? head_s[EW-1] : 1'b0;
  assign move_pin_1     = move_val ? head_s[2*PIN_W-1:PIN_W] : {PIN_W{1'b0}};
  assign move_pin_2     = move_val ? head_s[PIN_W-1:0] : {PIN_W{1'b0}};

  // Next-state, run bookkeeping and FIFO pointer logic.
  always_comb begin
    state_d  = state_q;
    limit_d  = limit_q;
    count_d  = count_q;
    wr_ptr_d = push_s ? (wr_ptr_q + (AW+1)'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + (AW+1)'(1)) : rd_ptr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_REQ;
          limit_d = move_limit;
          count_d = {CNT_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      S_REQ: begin
        // done takes priority over a move offered in the same cycle
        if (search_done) begin
          state_d = S_DRAIN;
        end else if (search_resp_val) begin
          state_d = S_RESP;
        end else begin
          state_d = S_REQ;
        end
      end
      S_RESP: begin
        if (push_s) begin
          state_d = S_GAP;
          count_d = (count_q == {CNT_W{1'b1}}) ? count_q : (count_q + CNT_W'(1));
        end else begin
          state_d = S_RESP;
        end
      end
      S_GAP: begin
        if (limit_hit_s || search_done) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (empty_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_val_d  = (state_d == S_REQ) || (state_d == S_RESP);
    busy_d     = !((state_d == S_IDLE) || (state_d == S_DONE));
    finished_d = (state_d == S_DONE);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      req_val_q  <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      count_q    <= {CNT_W{1'b0}};
      limit_q    <= {CNT_W{1'b0}};
      wr_ptr_q   <= {(AW+1){1'b0}};
      rd_ptr_q   <= {(AW+1){1'b0}};
    end else begin
      state_q    <= state_d;
      req_val_q  <= req_val_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care until written, outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {search_add_or_remove, search_pin_1, search_pin_2};
    end
  end

endmodule

// File: tb/tb_string_move_collector.sv
// Randomised bench for string_move_collector: a cycle-level behavioural model (move queue
// plus protocol phase) is compared against every DUT output on each falling edge.
module tb_string_move_collector;

  localparam int PIN_W = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] move_limit;
  logic             req_val;
  logic             resp_val;
  logic             resp_rdy;
  logic [PIN_W-1:0] pin_1, pin_2;
  logic             add_rm;
  logic             s_done;
  logic             move_val;
  logic             move_rdy;
  logic [PIN_W-1:0] move_pin_1, move_pin_2;
  logic             move_add;
  logic [CNT_W-1:0] move_count;
  logic             busy, finished;

  string_move_collector #(.PIN_W(PIN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .move_limit(move_limit),
    .search_req_val(req_val), .search_resp_val(resp_val), .search_resp_rdy(resp_rdy),
    .search_pin_1(pin_1), .search_pin_2(pin_2), .search_add_or_remove(add_rm),
    .search_done(s_done), .move_val(move_val), .move_rdy(move_rdy),
    .move_pin_1(move_pin_1), .move_pin_2(move_pin_2), .move_add(move_add),
    .move_count(move_count), .busy(busy), .finished(finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 request, 2 response, 3 gap, 4 drain, 5 done.
  int              m_phase;
  logic [16:0]     m_q[$];
  int              m_cnt, m_lim, pushes;
  bit              m_pushed;
  logic [PIN_W-1:0] popped[$];
  int              n_vec, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_q.delete(); m_cnt = 0; m_lim = 0; m_pushed = 1'b0;
  endtask

  task automatic model_step();
    bit push, pop;
    int ph;
    push = (m_phase == 2) && resp_val && (m_q.size() < DEPTH);
    pop  = (m_q.size() > 0) && move_rdy;
    ph   = m_phase;
    case (m_phase)
      0, 5: if (start) begin ph = 1; m_cnt = 0; m_lim = int'(move_limit); end
      1: if (s_done) ph = 4; else if (resp_val) ph = 2;
      2: if (push) ph = 3;
      3: ph = ((m_lim != 0 && m_cnt == m_lim) || s_done) ? 4 : 1;
      4: if (m_q.size() == 0) ph = 5;
      default: ph = 0;
    endcase
    if (pop) void'(m_q.pop_front());
    if (push) begin
      m_q.push_back({add_rm, pin_1, pin_2});
      if (m_cnt < 65535) m_cnt++;
      pushes++;
    end
    m_pushed = push;
    m_phase  = ph;
  endtask

  task automatic check_model();
    logic [16:0] h;
    h = (m_q.size() > 0) ? m_q[0] : 17'd0;
    n_vec++;
    chk("req_val",    req_val,    (m_phase == 1 || m_phase == 2));
    chk("resp_rdy",   resp_rdy,   (m_phase == 2 && m_q.size() < DEPTH));
    chk("move_val",   move_val,   (m_q.size() > 0));
    chk("move_add",   move_add,   h[16]);
    chk("move_pin_1", move_pin_1, h[15:8]);
    chk("move_pin_2", move_pin_2, h[7:0]);
    chk("move_count", move_count, m_cnt);
    chk("busy",       busy,       (m_phase >= 1 && m_phase <= 4));
    chk("finished",   finished,   (m_phase == 5));
  endtask

  task automatic cyc();
    if (move_val && move_rdy) popped.push_back(move_pin_1);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_start(input int lim);
    move_limit = CNT_W'(lim);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic finish_run();
    s_done = 1'b1; resp_val = 1'b1; move_rdy = 1'b1; start = 1'b0;
    for (int i = 0; i < 60 && m_phase != 5; i++) cyc();
    s_done = 1'b0; resp_val = 1'b0;
    chk("run_finished", finished, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k;
    n_vec = 0; n_err = 0; pushes = 0;
    reset = 1'b0; start = 1'b0; move_limit = '0; resp_val = 1'b0;
    pin_1 = '0; pin_2 = '0; add_rm = 1'b0; s_done = 1'b0; move_rdy = 1'b0;
    model_reset();
    @(negedge clk);
    check_model();
    chk("reset_req_val", req_val, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b1;
    cyc();

    // Single move, engine answers three cycles after the request.
    move_rdy = 1'b1;
    do_start(0);
    chk("t2_req_val", req_val, 1);
    cyc(); cyc();
    resp_val = 1'b1; pin_1 = 8'd5; pin_2 = 8'd77; add_rm = 1'b1;
    cyc(); cyc();
    chk("t2_move_val", move_val, 1);
    chk("t2_pin_1", move_pin_1, 5);
    chk("t2_pin_2", move_pin_2, 77);
    chk("t2_add", move_add, 1);
    chk("t2_count", move_count, 1);
    chk("t2_gap_req", req_val, 0);
    resp_val = 1'b0;
    cyc();
    chk("t2_req_again", req_val, 1);
    finish_run();

    // Fill the FIFO with the consumer stalled, then drain in order.
    move_rdy = 1'b0;
    do_start(0);
    resp_val = 1'b1; add_rm = 1'b0; base = pushes; k = 0;
    for (int i = 0; i < 40 && pushes - base < 4; i++) begin
      pin_1 = PIN_W'(k); pin_2 = PIN_W'(k);
      cyc();
      if (m_pushed) k++;
    end
    pin_1 = PIN_W'(k); pin_2 = PIN_W'(k);
    cyc(); cyc(); cyc();
    chk("t3_full_rdy", resp_rdy, 0);
    chk("t3_count4", move_count, 4);
    popped.delete();
    move_rdy = 1'b1;
    for (int i = 0; i < 40 && k < 6; i++) begin
      pin_1 = PIN_W'(k); pin_2 = PIN_W'(k);
      cyc();
      if (m_pushed) k++;
    end
    finish_run();
    chk("t3_count6", move_count, 6);
    chk("t3_popped_n", popped.size(), 6);
    for (int i = 0; i < popped.size(); i++) chk("t3_order", popped[i], i);

    // Move limit of three with an always-ready engine and consumer.
    move_rdy = 1'b1; resp_val = 1'b1; base = pushes;
    do_start(3);
    for (int i = 0; i < 60 && !finished; i++) cyc();
    chk("t4_handshakes", pushes - base, 3);
    chk("t4_count", move_count, 3);
    chk("t4_finished", finished, 1);

    // done arrives in REQ together with resp_val after two moves.
    base = pushes;
    do_start(0);
    for (int i = 0; i < 40 && !(pushes - base == 2 && m_phase == 1); i++) cyc();
    s_done = 1'b1;
    cyc();
    s_done = 1'b0;
    for (int i = 0; i < 40 && !finished; i++) cyc();
    chk("t5_handshakes", pushes - base, 2);
    chk("t5_count", move_count, 2);
    chk("t5_finished", finished, 1);
    resp_val = 1'b0;
    do_start(0);
    chk("t5_restart_count", move_count, 0);
    chk("t5_restart_req", req_val, 1);
    finish_run();

    // Random traffic: 100 moves with random consumer back-pressure.
    base = pushes;
    do_start(0);
    for (int i = 0; i < 4000 && pushes - base < 100; i++) begin
      resp_val = ($urandom_range(0, 3) != 0);
      pin_1 = PIN_W'($urandom); pin_2 = PIN_W'($urandom); add_rm = 1'($urandom);
      move_rdy = ($urandom_range(0, 2) == 0);
      cyc();
    end
    chk("t6_moves", (pushes - base >= 100), 1);
    finish_run();

    // Asynchronous reset while in RESP holding three entries.
    move_rdy = 1'b0; resp_val = 1'b1; base = pushes;
    do_start(0);
    for (int i = 0; i < 40 && !(pushes - base == 3 && m_phase == 2); i++) cyc();
    chk("t1_setup_val", move_val, 1);
    #2 reset = 1'b0;
    #1;
    chk("t1_req_val", req_val, 0);
    chk("t1_resp_rdy", resp_rdy, 0);
    chk("t1_move_val", move_val, 0);
    chk("t1_count", move_count, 0);
    chk("t1_busy", busy, 0);
    chk("t1_finished", finished, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    check_model();
    resp_val = 1'b0;
    cyc(); cyc();
    chk("t1_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
